// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  be_t;

  localparam int WORD_BYTES = 8;

endpackage

// File: rtl/dmem_array.sv
// Byte-enable word array: synchronous write, combinational read through a single word index.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  input  be_t           be,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  // Contents are deliberately not reset; only enabled byte lanes are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, LATENCY wait states, then a held
// response carrying read data or a store acknowledgement plus an error flag.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  word_t       req_wdata,
  input  be_t         req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output word_t       rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        enter_resp;
  logic        accept;

  logic        lat_write;
  logic [63:0] lat_addr;
  word_t       lat_wdata;
  be_t         lat_be;

  logic        op_write;
  logic [63:0] op_addr;
  word_t       op_wdata;
  be_t         op_be;
  logic        op_err;
  word_t       arr_rdata;

  assign accept = req_valid & req_ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the operation is performed on the accept edge itself,
  // so the live request fields are used instead of the latched copy.
  always_comb begin
    op_write = lat_write;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_be    = lat_be;
    if (state == IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_be    = req_be;
    end
  end

  assign op_err = (op_addr[2:0] != 3'd0) || (op_addr[63:AW+3] != '0);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (enter_resp & op_write & ~op_err),
    .addr (op_addr[AW+2:3]),
    .wdata(op_wdata),
    .be   (op_be),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_write) ? '0 : arr_rdata;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
